// File: rtl/voq_command_reader_pkg.sv
// voq_command_reader_pkg
//   Types shared by the VOQ read-side blocks: the 64-bit command word layout
//   and the output register state encoding.
package voq_command_reader_pkg;

  localparam int VOQ_CMD_W = 64;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] len;
    logic [47:0] addr;
  } voq_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rd_state_t;

endpackage

// File: rtl/voq_command_reader_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Searches upward from ptr+1 (wrapping
//   modulo N) for the first requesting index.
// Ports:
//   req        in  N   request vector
//   ptr        in  IW  index of the last granted requester
//   advance    in  1   allow the grant to be issued this cycle
//   grant      out N   one-hot grant, zero unless advance & any
//   grant_idx  out IW  index of the winning requester (valid when any)
//   any        out 1   at least one request is present
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin : search
    int          idx;
    logic [IW-1:0] ii;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    ii        = '0;
    // Offsets 1..N visit every requester once, ending on ptr itself.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      ii  = IW'(idx);
      if (!any && req[ii]) begin
        any       = 1'b1;
        grant_idx = ii;
      end
    end
    grant = (advance && any) ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/voq_command_reader.sv
// voq_command_reader
//   Read side of the VOQ command FIFOs (rclk domain). Round-robin pops one
//   command per cycle from non-empty, enabled FWFT FIFOs into a registered
//   valid/ready output. Words flagged uncorrectable are dropped; ECC events
//   are reported as registered one-cycle pulses.
//   Optional feature macro: VOQ_RD_ERRCNT_EN adds saturating sberr/dberr
//   event counters (sberr_cnt, dberr_cnt).
// Ports:
//   clk, rst                 clock, async active-high reset
//   q_empty/q_dout           per-queue FWFT empty flag and head word
//   q_sberr/q_dberr          per-queue ECC flags for the head word
//   q_re                     per-queue pop, one-hot or zero
//   q_mask                   per-queue arbitration enable
//   cmd_valid/cmd_ready      output handshake
//   cmd/cmd_qid              output command and its source queue
//   sberr_evt/dberr_evt      ECC event pulses, err_qid = source queue
//   sberr_cnt/dberr_cnt      saturating event counters (VOQ_RD_ERRCNT_EN)
module voq_command_reader
  import voq_command_reader_pkg::*;
#(
  parameter  int NQ    = 4,
  parameter  int WIDTH = 64,
  parameter  int CNT_W = 16,
  localparam int QW    = $clog2(NQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NQ-1:0]        q_empty,
  input  logic [NQ*WIDTH-1:0]  q_dout,
  input  logic [NQ-1:0]        q_sberr,
  input  logic [NQ-1:0]        q_dberr,
  output logic [NQ-1:0]        q_re,
  input  logic [NQ-1:0]        q_mask,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [VOQ_CMD_W-1:0] cmd,
  output logic [QW-1:0]        cmd_qid,
  output logic                 sberr_evt,
  output logic                 dberr_evt,
`ifdef VOQ_RD_ERRCNT_EN
  output logic [CNT_W-1:0]     sberr_cnt,
  output logic [CNT_W-1:0]     dberr_cnt,
`endif
  output logic [QW-1:0]        err_qid
);

  rd_state_t        state_p1, state_nx;
  voq_cmd_t         cmd_p1;
  logic [QW-1:0]    qid_p1;
  logic [QW-1:0]    rr_ptr;
  logic [QW-1:0]    err_qid_p1;
  logic             sberr_evt_p1, dberr_evt_p1;

  logic [NQ-1:0]    eligible;
  logic [NQ-1:0]    grant_oh;
  logic [QW-1:0]    grant_idx;
  logic             any;
  logic             can_load;
  logic             advance;
  logic             pop;
  logic             head_sb, head_db;
  logic [WIDTH-1:0] head_word;

  assign eligible  = ~q_empty & q_mask;
  assign can_load  = (state_p1 == ST_IDLE) | cmd_ready;
  // Hold pops off while reset is asserted so q_re reads zero in reset.
  assign advance   = can_load & ~rst;
  assign pop       = |grant_oh;
  assign head_sb   = q_sberr[grant_idx];
  assign head_db   = q_dberr[grant_idx];
  assign head_word = q_dout[int'(grant_idx)*WIDTH +: WIDTH];

  rr_arbiter #(.N(NQ)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .advance   (advance),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // ---- stage p0 -> p1: output register FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= ST_IDLE;
    else     state_p1 <= state_nx;
  end

  always_comb begin
    state_nx = state_p1;
    if (pop && !head_db)                           state_nx = ST_HOLD;
    else if ((state_p1 == ST_HOLD) && cmd_ready)   state_nx = ST_IDLE;
  end

  always_comb begin
    cmd_valid = (state_p1 == ST_HOLD);
    q_re      = grant_oh;
  end

  // ---- stage p0 -> p1: command, pointer and event registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_p1       <= '0;
      qid_p1       <= '0;
      rr_ptr       <= QW'(NQ - 1);
      err_qid_p1   <= '0;
      sberr_evt_p1 <= 1'b0;
      dberr_evt_p1 <= 1'b0;
    end else begin
      sberr_evt_p1 <= pop & head_sb & ~head_db;
      dberr_evt_p1 <= pop & head_db;
      if (pop) begin
        rr_ptr <= grant_idx;
        if (!head_db) begin
          cmd_p1 <= head_word;
          qid_p1 <= grant_idx;
        end
        if (head_sb || head_db) err_qid_p1 <= grant_idx;
      end
    end
  end

  assign cmd       = cmd_p1;
  assign cmd_qid   = qid_p1;
  assign err_qid   = err_qid_p1;
  assign sberr_evt = sberr_evt_p1;
  assign dberr_evt = dberr_evt_p1;

`ifdef VOQ_RD_ERRCNT_EN
  logic [CNT_W-1:0] sberr_cnt_p1, dberr_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---- stage p0 -> p1: event counters, updated with the pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sberr_cnt_p1 <= '0;
      dberr_cnt_p1 <= '0;
    end else begin
      if (pop && head_sb && !head_db) sberr_cnt_p1 <= sat_inc(sberr_cnt_p1);
      if (pop && head_db)             dberr_cnt_p1 <= sat_inc(dberr_cnt_p1);
    end
  end

  assign sberr_cnt = sberr_cnt_p1;
  assign dberr_cnt = dberr_cnt_p1;
`endif

endmodule
